// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU/MDU execute-stage block:
//   alu_op_e    - 4-bit operation code (ALU ops 0-7, MDU ops 8-13, no-ops 14-15)
//   alu_state_e - control FSM states
//   is_mdu_op() - true for the iterative multiply/divide operations (8-11)
// -----------------------------------------------------------------------------
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD   = 4'd0,
      OP_SUB   = 4'd1,
      OP_AND   = 4'd2,
      OP_OR    = 4'd3,
      OP_SRL   = 4'd4,
      OP_SRA   = 4'd5,
      OP_GTU   = 4'd6,
      OP_GT    = 4'd7,
      OP_MULTU = 4'd8,
      OP_MULT  = 4'd9,
      OP_DIVU  = 4'd10,
      OP_DIV   = 4'd11,
      OP_MTHI  = 4'd12,
      OP_MTLO  = 4'd13,
      OP_NOP14 = 4'd14,
      OP_NOP15 = 4'd15
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } alu_state_e;

   // Ops 8..11 share the 4'b10xx prefix.
   function automatic logic is_mdu_op(input logic [3:0] op);
      return (op[3:2] == 2'b10);
   endfunction

endpackage

// File: rtl/alu_divider.sv
// -----------------------------------------------------------------------------
// alu_divider
// One restoring-division step on unsigned magnitudes. The partial remainder
// and the dividend/quotient shift register live in the caller; this block
// only computes their next values.
//   rem      in  WIDTH  current partial remainder
//   quo      in  WIDTH  dividend bits still to shift in / quotient bits so far
//   divisor  in  WIDTH  divisor magnitude
//   rem_next out WIDTH  partial remainder after this step
//   quo_next out WIDTH  shift register after this step (new quotient bit in LSB)
// -----------------------------------------------------------------------------
module alu_divider #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] quo_next
);

   logic [WIDTH:0] trial;
   logic [WIDTH:0] diff;

   // Trial subtraction; since rem < divisor always holds, the top bit of diff
   // is exactly the borrow. A zero divisor never borrows, so the remainder
   // ends up equal to the dividend and the quotient to all ones.
   always_comb begin
      trial = {rem, quo[WIDTH-1]};
      diff  = trial - {1'b0, divisor};
      if (diff[WIDTH] == 1'b0) begin
         rem_next = diff[WIDTH-1:0];
         quo_next = {quo[WIDTH-2:0], 1'b1};
      end else begin
         rem_next = trial[WIDTH-1:0];
         quo_next = {quo[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/alu_mdu.sv
// -----------------------------------------------------------------------------
// alu_mdu
// EX-stage ALU with iterative multiply/divide and persistent HI/LO registers,
// behind a valid/ready handshake on both sides.
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   request handshake; A, B, ALUOp sampled at accept
//   out_valid/out_ready result handshake; C held while out_valid && !out_ready
//   C                   registered result
//   HI, LO              multiply/divide result registers (also MTHI/MTLO)
//   busy                multiply/divide iteration or fixup in progress
// Single-cycle ops complete at the accept edge; MUL/DIV take WIDTH step
// cycles plus one fixup cycle regardless of operand values.
// -----------------------------------------------------------------------------
module alu_mdu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       ALUOp,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] C,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic             busy
);

   localparam int             SHW        = $clog2(WIDTH);
   localparam logic [SHW-1:0] LAST_COUNT = SHW'(WIDTH - 1);
   localparam logic [SHW-1:0] CNT_ZERO   = {SHW{1'b0}};
   localparam logic [SHW-1:0] CNT_ONE    = {{(SHW-1){1'b0}}, 1'b1};

   alu_state_e         state;
   logic               fixup;      // last busy cycle: apply signs, write results
   logic               neg_res;    // product / quotient must be negated
   logic               neg_rem;    // remainder takes the dividend's sign
   logic [SHW-1:0]     count;
   logic [WIDTH-1:0]   opnd;       // multiplicand or divisor magnitude
   logic [WIDTH-1:0]   acc_hi;     // product high half / partial remainder
   logic [WIDTH-1:0]   acc_lo;     // multiplier / dividend-quotient shift reg

   logic               accept;
   logic               op_signed;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH-1:0]   alu_res;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH-1:0]   rem_next;
   logic [WIDTH-1:0]   quo_next;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);
   assign busy      = (state == ST_MUL) || (state == ST_DIV);
   assign accept    = in_valid && in_ready;

   // MULT and DIV (9, 11) are the odd MDU codes.
   assign op_signed = ALUOp[0];
   assign a_mag     = (op_signed && A[WIDTH-1]) ? -A : A;
   assign b_mag     = (op_signed && B[WIDTH-1]) ? -B : B;

   // Result of the single-cycle operations.
   always_comb begin
      alu_res = {WIDTH{1'b0}};
      case (ALUOp)
         OP_ADD:  alu_res = A + B;
         OP_SUB:  alu_res = A - B;
         OP_AND:  alu_res = A & B;
         OP_OR:   alu_res = A | B;
         OP_SRL:  alu_res = A >> B[SHW-1:0];
         OP_SRA:  alu_res = $signed(A) >>> B[SHW-1:0];
         OP_GTU:  alu_res = {{(WIDTH-1){1'b0}}, (A > B)};
         OP_GT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) > $signed(B))};
         OP_MTHI: alu_res = A;
         OP_MTLO: alu_res = A;
         default: alu_res = {WIDTH{1'b0}};
      endcase
   end

   // Shift-add multiply step: add multiplicand when the multiplier LSB is set,
   // then shift {acc_hi, acc_lo} right by one (carry enters acc_hi's MSB).
   always_comb begin
      if (acc_lo[0]) begin
         mul_sum = {1'b0, acc_hi} + {1'b0, opnd};
      end else begin
         mul_sum = {1'b0, acc_hi};
      end
   end

   alu_divider #(
      .WIDTH (WIDTH)
   ) u_div (
      .rem      (acc_hi),
      .quo      (acc_lo),
      .divisor  (opnd),
      .rem_next (rem_next),
      .quo_next (quo_next)
   );

   // Sign fixup and divide-by-zero override applied in the fixup cycle.
   // MIN / -1 needs no special case: |MIN| / 1 negated twice stays MIN, rem 0.
   always_comb begin
      if (neg_res) begin
         prod_fix = -{acc_hi, acc_lo};
         quo_fix  = -acc_lo;
      end else begin
         prod_fix = {acc_hi, acc_lo};
         quo_fix  = acc_lo;
      end
      if (opnd == {WIDTH{1'b0}}) begin
         quo_fix = {WIDTH{1'b1}};
      end else begin
         quo_fix = quo_fix;
      end
      // Divide-by-zero leaves |A| in the remainder, so this also restores A.
      if (neg_rem) begin
         rem_fix = -acc_hi;
      end else begin
         rem_fix = acc_hi;
      end
   end

   // Control FSM with the operand/accumulator datapath and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         fixup   <= 1'b0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         count   <= CNT_ZERO;
         opnd    <= {WIDTH{1'b0}};
         acc_hi  <= {WIDTH{1'b0}};
         acc_lo  <= {WIDTH{1'b0}};
         C       <= {WIDTH{1'b0}};
         HI      <= {WIDTH{1'b0}};
         LO      <= {WIDTH{1'b0}};
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (is_mdu_op(ALUOp)) begin
                     state   <= ALUOp[1] ? ST_DIV : ST_MUL;
                     fixup   <= 1'b0;
                     count   <= LAST_COUNT;
                     neg_res <= op_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
                     neg_rem <= op_signed && A[WIDTH-1];
                     acc_hi  <= {WIDTH{1'b0}};
                     if (ALUOp[1]) begin
                        acc_lo <= a_mag;
                        opnd   <= b_mag;
                     end else begin
                        acc_lo <= b_mag;
                        opnd   <= a_mag;
                     end
                  end else begin
                     state <= ST_DONE;
                     C     <= alu_res;
                     if (ALUOp == OP_MTHI) begin
                        HI <= A;
                     end else if (ALUOp == OP_MTLO) begin
                        LO <= A;
                     end
                  end
               end
            end
            ST_MUL: begin
               if (fixup) begin
                  HI    <= prod_fix[2*WIDTH-1:WIDTH];
                  LO    <= prod_fix[WIDTH-1:0];
                  C     <= prod_fix[WIDTH-1:0];
                  fixup <= 1'b0;
                  state <= ST_DONE;
               end else begin
                  acc_hi <= mul_sum[WIDTH:1];
                  acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                  if (count == CNT_ZERO) begin
                     fixup <= 1'b1;
                  end else begin
                     count <= count - CNT_ONE;
                  end
               end
            end
            ST_DIV: begin
               if (fixup) begin
                  HI    <= rem_fix;
                  LO    <= quo_fix;
                  C     <= quo_fix;
                  fixup <= 1'b0;
                  state <= ST_DONE;
               end else begin
                  acc_hi <= rem_next;
                  acc_lo <= quo_next;
                  if (count == CNT_ZERO) begin
                     fixup <= 1'b1;
                  end else begin
                     count <= count - CNT_ONE;
                  end
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
               fixup <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mdu.sv
// -----------------------------------------------------------------------------
// tb_alu_mdu
// Self-checking bench for alu_mdu (WIDTH=32 plus a WIDTH=8 instance).
// Expected results come from a plain-arithmetic reference model using 64-bit
// integer multiply/divide; HI/LO expectations are tracked in m_hi/m_lo.
// -----------------------------------------------------------------------------
module tb_alu_mdu;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] A = 32'd0;
   logic [31:0] B = 32'd0;
   logic [3:0]  ALUOp = 4'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] C;
   logic [31:0] HI;
   logic [31:0] LO;
   logic        busy;

   logic        in_valid8 = 1'b0;
   logic        in_ready8;
   logic [7:0]  A8 = 8'd0;
   logic [7:0]  B8 = 8'd0;
   logic [3:0]  ALUOp8 = 4'd0;
   logic        out_valid8;
   logic        out_ready8 = 1'b0;
   logic [7:0]  C8;
   logic [7:0]  HI8;
   logic [7:0]  LO8;
   logic        busy8;

   int          total = 0;
   int          bad = 0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   alu_mdu #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .ALUOp(ALUOp), .out_valid(out_valid), .out_ready(out_ready),
      .C(C), .HI(HI), .LO(LO), .busy(busy)
   );

   alu_mdu #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .A(A8), .B(B8), .ALUOp(ALUOp8), .out_valid(out_valid8), .out_ready(out_ready8),
      .C(C8), .HI(HI8), .LO(LO8), .busy(busy8)
   );

   // Reference model: architectural result of one operation.
   function automatic void ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] hi_in, input logic [31:0] lo_in,
                                  output logic [31:0] c, output logic [31:0] hi, output logic [31:0] lo);
      longint      sa, sb, sq, sr;
      logic [63:0] p;
      int          sh;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sh = int'(b[4:0]);
      hi = hi_in;
      lo = lo_in;
      c  = 32'd0;
      case (op)
         4'd0: c = a + b;
         4'd1: c = a - b;
         4'd2: c = a & b;
         4'd3: c = a | b;
         4'd4: c = a >> sh;
         4'd5: begin sq = sa >>> sh; c = sq[31:0]; end
         4'd6: c = (a > b) ? 32'd1 : 32'd0;
         4'd7: c = (sa > sb) ? 32'd1 : 32'd0;
         4'd8: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; c = lo; end
         4'd9: begin sq = sa * sb; p = sq; hi = p[63:32]; lo = p[31:0]; c = lo; end
         4'd10: begin
            if (b == 32'd0) begin lo = 32'hFFFFFFFF; hi = a; end
            else begin lo = a / b; hi = a % b; end
            c = lo;
         end
         4'd11: begin
            if (b == 32'd0) begin lo = 32'hFFFFFFFF; hi = a; end
            else begin sq = sa / sb; sr = sa % sb; lo = sq[31:0]; hi = sr[31:0]; end
            c = lo;
         end
         4'd12: begin hi = a; c = a; end
         4'd13: begin lo = a; c = a; end
         default: c = 32'd0;
      endcase
   endfunction

   // Issue one op, wait (bounded) for the result, take it; checks protocol on the way.
   task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] c_obs, output int lat, output int busy_cnt);
      int guard = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL ready_wait: in_ready=%b required 1", in_ready); end
      ALUOp = op; A = a; B = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1; busy_cnt = 0;
      @(negedge clk);
      while (out_valid !== 1'b1 && lat < 100) begin
         if (busy === 1'b1) busy_cnt++;
         total++;
         if (in_ready !== 1'b0 || HI !== m_hi || LO !== m_lo) begin
            bad++;
            $display("FAIL busy_hold: in_ready=%b HI=%h LO=%h required 0 %h %h", in_ready, HI, LO, m_hi, m_lo);
         end
         ALUOp = 4'd12; A = 32'hDEADBEEF; in_valid = 1'b1;   // must be ignored
         @(negedge clk); lat++;
      end
      in_valid = 1'b0;
      c_obs = C;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL after_take: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_reset();
      #12;
      total++;
      if (C !== 32'd0 || HI !== 32'd0 || LO !== 32'd0 || out_valid !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: C=%h HI=%h LO=%h ov=%b busy=%b required all 0", C, HI, LO, out_valid, busy);
      end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: in_ready=%b required 1", in_ready); end
   endtask

   task automatic test_shift();
      logic [31:0] c; int lat, bc;
      do_op(4'd5, 32'h80000000, 32'h00000024, c, lat, bc);
      total++;
      if (c !== 32'hF8000000 || lat != 1) begin bad++; $display("FAIL sra: C=%h lat=%0d required F8000000 1", c, lat); end
      total++;
      if (HI !== 32'd0 || LO !== 32'd0) begin bad++; $display("FAIL sra_hilo: HI=%h LO=%h required 0 0", HI, LO); end
   endtask

   task automatic test_mult();
      logic [31:0] c; int lat, bc;
      do_op(4'd9, 32'hFFFFFFFD, 32'd7, c, lat, bc);
      total++;
      if (lat != 34 || bc != 33) begin bad++; $display("FAIL mult_timing: lat=%0d busy=%0d required 34 33", lat, bc); end
      total++;
      if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFEB || c !== 32'hFFFFFFEB) begin
         bad++; $display("FAIL mult: HI=%h LO=%h C=%h required FFFFFFFF FFFFFFEB FFFFFFEB", HI, LO, c);
      end
      m_hi = 32'hFFFFFFFF; m_lo = 32'hFFFFFFEB;
   endtask

   task automatic test_div();
      logic [31:0] c; int lat, bc;
      do_op(4'd11, 32'hFFFFFFF9, 32'd2, c, lat, bc);
      total++;
      if (LO !== 32'hFFFFFFFD || HI !== 32'hFFFFFFFF || c !== 32'hFFFFFFFD || lat != 34) begin
         bad++; $display("FAIL div_neg: LO=%h HI=%h C=%h lat=%0d required FFFFFFFD FFFFFFFF FFFFFFFD 34", LO, HI, c, lat);
      end
      m_hi = 32'hFFFFFFFF; m_lo = 32'hFFFFFFFD;
      do_op(4'd11, 32'h80000000, 32'hFFFFFFFF, c, lat, bc);
      total++;
      if (LO !== 32'h80000000 || HI !== 32'd0 || lat != 34) begin
         bad++; $display("FAIL div_min_m1: LO=%h HI=%h lat=%0d required 80000000 0 34", LO, HI, lat);
      end
      m_hi = 32'd0; m_lo = 32'h80000000;
   endtask

   task automatic test_divzero();
      logic [31:0] c; int lat, bc;
      do_op(4'd10, 32'h00001234, 32'd0, c, lat, bc);
      total++;
      if (LO !== 32'hFFFFFFFF || HI !== 32'h00001234 || lat != 34) begin
         bad++; $display("FAIL divzero: LO=%h HI=%h lat=%0d required FFFFFFFF 1234 34", LO, HI, lat);
      end
      m_hi = 32'h00001234; m_lo = 32'hFFFFFFFF;
   endtask

   task automatic test_alu_random();
      logic [31:0] a, b, c, ec, eh, el; logic [3:0] op; int lat, bc;
      for (int i = 0; i < 30; i++) begin
         op = 4'($urandom_range(0, 11));
         if (op > 4'd7) op = op + 4'd4;
         a = $urandom; b = $urandom;
         if (i % 5 == 0) b = a;
         ref_op(op, a, b, m_hi, m_lo, ec, eh, el);
         do_op(op, a, b, c, lat, bc);
         total++;
         if (c !== ec || HI !== eh || LO !== el || lat != 1) begin
            bad++;
            $display("FAIL alu_rand op=%0d a=%h b=%h: C=%h HI=%h LO=%h lat=%0d required %h %h %h 1",
                     op, a, b, c, HI, LO, lat, ec, eh, el);
         end
         m_hi = eh; m_lo = el;
      end
   endtask

   task automatic test_mdu_random();
      logic [31:0] a, b, c, ec, eh, el; logic [3:0] op; int lat, bc;
      for (int i = 0; i < 12; i++) begin
         op = 4'd8 + 4'($urandom_range(0, 3));
         a = $urandom;
         case ($urandom_range(0, 3))
            0: b = 32'd0;
            1: b = 32'($urandom_range(1, 15));
            2: b = 32'd0 - 32'($urandom_range(1, 15));
            default: b = $urandom;
         endcase
         ref_op(op, a, b, m_hi, m_lo, ec, eh, el);
         do_op(op, a, b, c, lat, bc);
         total++;
         if (c !== ec || HI !== eh || LO !== el || lat != 34) begin
            bad++;
            $display("FAIL mdu_rand op=%0d a=%h b=%h: C=%h HI=%h LO=%h lat=%0d required %h %h %h 34",
                     op, a, b, c, HI, LO, lat, ec, eh, el);
         end
         m_hi = eh; m_lo = el;
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      ALUOp = 4'd6; A = 32'd1; B = 32'hFFFFFFFF; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++;
         if (out_valid !== 1'b1 || C !== 32'd0 || in_ready !== 1'b0 || HI !== m_hi || LO !== m_lo) begin
            bad++;
            $display("FAIL backpressure cyc=%0d: ov=%b C=%h in_ready=%b HI=%h LO=%h required 1 0 0 %h %h",
                     i, out_valid, C, in_ready, HI, LO, m_hi, m_lo);
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      ALUOp = 4'd0; A = 32'd5; B = 32'd7; in_valid = 1'b1;
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready: in_ready=%b required 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || C !== 32'd12) begin
         bad++; $display("FAIL b2b_result: ov=%b C=%h required 1 0000000c", out_valid, C);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_mid_reset();
      logic [31:0] a, b, c, ec, eh, el; int lat, bc;
      @(negedge clk);
      ALUOp = 4'd8; A = 32'hFFFF0001; B = 32'h00012345; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (C !== 32'd0 || HI !== 32'd0 || LO !== 32'd0 || out_valid !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset: C=%h HI=%h LO=%h ov=%b busy=%b required all 0", C, HI, LO, out_valid, busy);
      end
      @(negedge clk); rst_n = 1'b1;
      m_hi = 32'd0; m_lo = 32'd0;
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready: in_ready=%b required 1", in_ready); end
      a = $urandom; b = $urandom;
      ref_op(4'd8, a, b, m_hi, m_lo, ec, eh, el);
      do_op(4'd8, a, b, c, lat, bc);
      total++;
      if (c !== ec || HI !== eh || LO !== el || lat != 34) begin
         bad++; $display("FAIL post_reset_op: C=%h HI=%h LO=%h lat=%0d required %h %h %h 34", c, HI, LO, lat, ec, eh, el);
      end
      m_hi = eh; m_lo = el;
   endtask

   task automatic test_width8();
      int lat = 1;
      @(negedge clk);
      ALUOp8 = 4'd8; A8 = 8'hFF; B8 = 8'hFF; in_valid8 = 1'b1;
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      @(negedge clk);
      while (out_valid8 !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
      total++;
      if (HI8 !== 8'hFE || LO8 !== 8'h01 || C8 !== 8'h01 || lat != 10) begin
         bad++; $display("FAIL w8_multu: HI=%h LO=%h C=%h lat=%0d required fe 01 01 10", HI8, LO8, C8, lat);
      end
      out_ready8 = 1'b1;
      @(posedge clk); #1;
      out_ready8 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_shift();
      test_mult();
      test_div();
      test_divzero();
      test_alu_random();
      test_mdu_random();
      test_back_to_back();
      test_mid_reset();
      test_width8();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
